// File: rtl/hidden_layer_sequencer.sv
// Time-multiplexed hidden-layer evaluator: one shared MAC walks N_HID neurons x N_IN
// weights from a synchronous ROM, then ReLU-saturates each dot product onto a valid/ready port.
module hidden_layer_sequencer #(
  parameter int N_IN  = 10,
  parameter int N_HID = 10,
  parameter int DW    = 10,
  parameter int ACC_W = 24,
  parameter int SHIFT = 9,
  parameter int AW    = $clog2(N_IN*N_HID)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_IN*DW-1:0]       in_data,
  output logic                     busy,
  output logic                     w_rd,
  output logic [AW-1:0]            w_addr,
  input  logic [DW-1:0]            w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N_HID)-1:0] out_idx,
  output logic [DW-1:0]            out_data,
  output logic                     done,
  output logic [2:0]               dbg_state_o
);

  localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NW = $clog2(N_HID);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_LAST, S_OUT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [N_IN*DW-1:0]        in_q, in_d;
  logic                      busy_q, busy_d;
  logic                      rd_q, rd_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic                      pend_q, pend_d;
  logic [JW-1:0]             j_q, j_d, jd_q, jd_d;
  logic [NW-1:0]             n_q, n_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      ov_q, ov_d;
  logic [NW-1:0]             idx_q, idx_d;
  logic [DW-1:0]             od_q, od_d;
  logic                      done_q, done_d;

  logic signed [DW:0]        x_s;
  logic signed [2*DW:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext, sum, shifted;
  logic [DW-1:0]             act;

  // Output handshake: a result transfers on a rising edge where out_valid and out_ready
  // are both high; out_valid, out_idx and out_data stay frozen until that edge.
  assign busy        = busy_q;
  assign w_rd        = rd_q;
  assign w_addr      = addr_q;
  assign out_valid   = ov_q;
  assign out_idx     = idx_q;
  assign out_data    = od_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    busy_d  = busy_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    pend_d  = rd_q;
    jd_d    = j_q;
    j_d     = j_q;
    n_d     = n_q;
    ov_d    = ov_q;
    idx_d   = idx_q;
    od_d    = od_q;
    done_d  = 1'b0;

    // pend_q marks that w_data holds the weight for element jd_q this cycle.
    x_s      = $signed({1'b0, in_q[jd_q*DW +: DW]});
    prod     = x_s * $signed(w_data);
    prod_ext = $signed({{(ACC_W-2*DW-1){prod[2*DW]}}, prod});
    sum      = pend_q ? (acc_q + prod_ext) : acc_q;
    acc_d    = sum;

    shifted = sum >>> SHIFT;
    if (sum[ACC_W-1])                act = '0;
    else if (|shifted[ACC_W-1:DW])   act = '1;
    else                             act = shifted[DW-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d    = in_data;
          n_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          rd_d    = 1'b1;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (j_q == JW'(N_IN-1)) begin
          rd_d    = 1'b0;
          state_d = S_LAST;
        end else begin
          j_d    = j_q + JW'(1);
          addr_d = addr_q + AW'(1);
        end
      end
      S_LAST: begin
        od_d    = act;
        idx_d   = n_q;
        ov_d    = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          ov_d = 1'b0;
          if (n_q == NW'(N_HID-1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // Addresses are contiguous across neurons, so the next base is simply +1.
            n_d     = n_q + NW'(1);
            j_d     = '0;
            acc_d   = '0;
            rd_d    = 1'b1;
            addr_d  = addr_q + AW'(1);
            state_d = S_MAC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      busy_q <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      pend_q <= 1'b0;
      j_q    <= '0;
      jd_q   <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      ov_q   <= 1'b0;
      idx_q  <= '0;
      od_q   <= '0;
      done_q <= 1'b0;
    end else begin
      in_q   <= in_d;
      busy_q <= busy_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      j_q    <= j_d;
      jd_q   <= jd_d;
      n_q    <= n_d;
      acc_q  <= acc_d;
      ov_q   <= ov_d;
      idx_q  <= idx_d;
      od_q   <= od_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Directed bench for hidden_layer_sequencer: synchronous ROM model, expected-result queue
// with a popping monitor, address-order monitor and cycle-accurate schedule checks.
module tb_hidden_layer_sequencer;

  localparam int N_IN  = 10;
  localparam int N_HID = 10;
  localparam int DW    = 10;
  localparam int AW    = 7;
  localparam int NW    = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [N_IN*DW-1:0] in_data;
  logic              busy;
  logic              w_rd;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic              out_valid;
  logic              out_ready;
  logic [NW-1:0]     out_idx;
  logic [DW-1:0]     out_data;
  logic              done;
  logic [2:0]        dbg_state;

  logic [DW-1:0]     rom [N_IN*N_HID];
  logic [NW+DW-1:0]  exp_q [$];

  int checks = 0;
  int errors = 0;
  int pc = 0;
  int p0 = 0;
  int exp_addr = 0;

  hidden_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .busy(busy),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data), .done(done),
    .dbg_state_o(dbg_state)
  );

  // clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // synchronous weight ROM
  always @(posedge clk) if (w_rd) w_data <= rom[w_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, pc - p0);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [NW+DW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got idx=%0d data=%0d, expected no result", out_idx, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_idx, out_data} != e) begin
          errors++;
          $display("FAIL out_neuron: got idx=%0d data=%0d, expected idx=%0d data=%0d",
                   out_idx, out_data, e[NW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // address-order monitor
  always @(negedge clk) begin
    if (rst_n && w_rd) begin
      checks++;
      if (int'(w_addr) != exp_addr) begin
        errors++;
        $display("FAIL rom_addr: got %0d, expected %0d", w_addr, exp_addr);
      end
      exp_addr++;
    end
  end

  // driver tasks
  task automatic load(input int inv, input int wv);
    for (int j = 0; j < N_IN; j++) in_data[j*DW +: DW] = DW'(inv);
    for (int a = 0; a < N_IN*N_HID; a++) rom[a] = DW'(wv);
  endtask

  task automatic push_all(input int v);
    for (int n = 0; n < N_HID; n++) exp_q.push_back({NW'(n), DW'(v)});
  endtask

  task automatic start_eval();
    exp_addr = 0;
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #1;
    p0 = pc - 1;
    start = 1'b0;
    // later input changes must not affect the captured vector
    for (int j = 0; j < N_IN; j++) in_data[j*DW +: DW] = DW'($urandom_range(0, 1023));
  endtask

  task automatic wait_done(input int exp_cycle, input string name);
    bit seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: done never seen, expected at cycle %0d", name, exp_cycle);
    end else begin
      chk({name, "_cycle"}, pc - p0, exp_cycle);
      chk({name, "_busy"}, int'(busy), 0);
    end
    @(posedge clk); #2;
    chk({name, "_addr_count"}, exp_addr, N_IN*N_HID);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_w_rd"}, int'(w_rd), 0);
    chk({name, "_w_addr"}, int'(w_addr), 0);
    chk({name, "_out_valid"}, int'(out_valid), 0);
    chk({name, "_out_idx"}, int'(out_idx), 0);
    chk({name, "_out_data"}, int'(out_data), 0);
    chk({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; in_data = '0;
    load(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // nominal: 100*256*10 >> 9 = 500
    load(100, 256);
    push_all(500);
    start_eval();
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("first_valid_cycle", seen ? pc - p0 : -1, 12);
    chk("first_valid_busy", int'(busy), 1);
    wait_done(121, "nominal");

    // ReLU clamp: negative weights, random inputs
    for (int a = 0; a < N_IN*N_HID; a++) rom[a] = 10'h3FF;
    for (int j = 0; j < N_IN; j++) in_data[j*DW +: DW] = DW'($urandom_range(1, 1023));
    push_all(0);
    start_eval();
    wait_done(121, "relu");

    // saturation: 1023*511*10 = 5227530, >>9 = 10210 -> 1023
    load(1023, 511);
    push_all(1023);
    start_eval();
    wait_done(121, "saturate");

    // address map: only neuron 3, weight 6 nonzero; 1000*511 >> 9 = 998
    load(50, 0);
    in_data[6*DW +: DW] = DW'(1000);
    rom[3*N_IN + 6] = DW'(511);
    for (int n = 0; n < N_HID; n++) exp_q.push_back({NW'(n), (n == 3) ? DW'(998) : DW'(0)});
    start_eval();
    wait_done(121, "addr_map");

    // back-pressure: out_ready low for 5 cycles at neuron 0
    load(100, 256);
    push_all(500);
    out_ready = 1'b0;
    start_eval();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c >= 12) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_idx", int'(out_idx), 0);
        chk("stall_data", int'(out_data), 500);
        chk("stall_w_rd", int'(w_rd), 0);
      end
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_done(126, "stall");

    // reset during neuron 3 MAC, with an ignored second start before it
    load(100, 256);
    push_all(500);
    start_eval();
    while (pc - p0 < 20) begin @(posedge clk); #2; end
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    while (pc - p0 < 40) begin @(posedge clk); #2; end
    chk("pre_reset_popped", exp_q.size(), 7);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // full run after reset: 300*100*10 >> 9 = 585
    load(300, 100);
    push_all(585);
    start_eval();
    wait_done(121, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hidden_layer_sequencer.md
# hidden_layer_sequencer

Time-multiplexed controller that evaluates a full hidden layer (N_HID neurons, each with N_IN inputs) on one shared multiply-accumulate datapath. It captures an input vector on `start` and reads weights one per cycle from an external synchronous weight ROM. After each neuron's dot product it applies a shift-and-ReLU-saturate activation and presents the neuron result on a valid/ready output port. It sits between the feature-extraction front end and the output layer, replacing N_HID parallel combinational neurons.

## Interface
- `N_IN`, 10, inputs per neuron.
- `N_HID`, 10, neurons in the layer.
- `DW`, 10, width of inputs (unsigned), weights (signed) and outputs (unsigned).
- `ACC_W`, 24, signed accumulator width.
- `SHIFT`, 9, fractional bits of weights (Q1.9); the accumulator is arithmetically right-shifted by SHIFT before saturation.
- `AW`, $clog2(N_IN*N_HID), weight ROM address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a layer evaluation; sampled only in IDLE.
- `in_data`  in  N_IN*DW  input vector, element j at bits [j*DW +: DW]; captured on the accepted `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `w_rd`  out  1  weight ROM read enable.
- `w_addr`  out  AW  ROM address = neuron*N_IN + j.
- `w_data`  in  DW  signed weight, valid exactly one cycle after `w_rd`.
- `out_valid`  out  1  neuron result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_idx`  out  $clog2(N_HID)  neuron index of `out_data`.
- `out_data`  out  DW  activated neuron output.
- `done`  out  1  one-cycle pulse after the last neuron is accepted.

## Operation
- States: IDLE, MAC, LAST, OUT, DONE.
- IDLE: if `start`=1, latch `in_data`, set n=0, j=0, acc=0 -> MAC. Otherwise stay in IDLE.
- MAC: `w_rd`=1, `w_addr`=n*N_IN+j, j++. When j==N_IN-1 the issue completes -> LAST.
- Accumulate: in every cycle where `w_rd` was high in the previous cycle, acc += $signed({1'b0,in[j_d]}) * $signed(w_data). Here j_d is j delayed one cycle. The product is DW*2+1 bits signed, sign-extended to ACC_W.
- LAST: `w_rd`=0. Add the final product, then register the activation of the final sum into `out_data`, with `out_idx`=n -> OUT.
- Activation: if acc<0 the output is 0. Otherwise s = acc>>>SHIFT, and the output is s clamped to 2^DW-1.
- OUT: `out_valid`=1; `out_data` and `out_idx` are held stable. On `out_ready`=1: if n==N_HID-1 -> DONE; else n++, j=0, acc=0 -> MAC.
- DONE: `done`=1 and `busy`=0 for one cycle -> IDLE.
- `start` outside IDLE is ignored; `in_data` changes after capture have no effect.
- `out_ready` while `out_valid`=0 is ignored.
- No ROM reads are issued in LAST, OUT, DONE or IDLE.
- Each address 0..N_IN*N_HID-1 is issued exactly once per evaluation, in ascending order.
- Reset (asynchronous, any state): state=IDLE. `busy`, `w_rd`, `out_valid` and `done` are 0. `w_addr`, `out_idx`, `out_data`, acc, n and j are 0. Any pending ROM data is discarded.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..N_IN: MAC, with `w_addr` n*N_IN+0 .. n*N_IN+N_IN-1.
- Cycle N_IN+1: LAST.
- Cycle N_IN+2: OUT with `out_valid`=1 (cycle 12 at default parameters).
- With `out_ready` held high, each neuron occupies N_IN+2 cycles. Neuron n's result appears at cycle 12+12n, and `done` pulses at cycle 121 for the defaults.
- Each cycle of `out_ready`=0 in OUT adds exactly one cycle to the schedule.
- All outputs are registered; there is no combinational path from `out_ready` or `start` to any output.
- The accumulator cannot overflow: the maximum magnitude is 1023*512*10 < 2^23.

## Test plan
- Inputs all 100, weights all 256 -> 10 outputs of `out_data`=500, `out_idx` 0..9, `done` at cycle 121.
- Weights all -1, random inputs -> every `out_data`=0 (ReLU clamp).
- Inputs all 1023, weights all 511 -> acc=5,227,530, s=10210 -> every `out_data`=1023 (saturation).
- Only weight 6 of neuron 3 = 511, all others 0; input[6]=1000 -> neuron 3 outputs 998 and all other neurons output 0. This checks the address map.
- `out_ready` held low 5 cycles at neuron 0 -> `out_valid` is held, `out_data`/`out_idx` are stable, `w_rd`=0 throughout, and `done` slips to cycle 126.
- `rst_n` low during MAC of neuron 3 -> all outputs are 0 immediately. A second `start` pulse during busy is ignored; a new `start` after reset yields the full correct sequence from neuron 0 with addresses 0..99.
